// File: rtl/tta_regfile_p_if.sv
// rtl/tta_regfile_p_if.sv - move/branch instruction bus and PC/stall returns of the TTA register file
interface tta_regfile_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] i_src;
  logic [ADDR_W-1:0] i_dst;
  logic              i_lw;
  logic [DATA_W-1:0] i_imm;
  logic              i_j;
  logic              i_br;
  logic              i_br_sel;
  logic              i_br_inv;
  logic [DATA_W-1:0] o_pc;
  logic              o_stall;

  modport master (
    output i_src, i_dst, i_lw, i_imm, i_j, i_br, i_br_sel, i_br_inv,
    input  o_pc, o_stall
  );

  modport slave (
    input  i_src, i_dst, i_lw, i_imm, i_j, i_br, i_br_sel, i_br_inv,
    output o_pc, o_stall
  );
endinterface

// File: rtl/tta_regfile_p.sv
// rtl/tta_regfile_p.sv - move-triggered register file with function units, GPRs and an iterative multiplier
module tta_regfile_p #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input logic           i_clk,
  input logic           i_rst,
  tta_regfile_p_if.slave bus
);
  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [ADDR_W-1:0] A_PC     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_RES_HI = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] A_MUL_R  = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] A_BUSY   = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] A_OPR_LO = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] A_MUL_A  = ADDR_W'(31);
  localparam logic [ADDR_W-1:0] A_MUL_B  = ADDR_W'(32);
  localparam logic [ADDR_W-1:0] A_GPR_LO = ADDR_W'(40);

  typedef enum logic {S_IDLE, S_RUN} mul_state_e;

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] res_q [1:9];
  logic [DATA_W-1:0] res_d [1:9];
  logic [DATA_W-1:0] opr_q [14:32];
  logic [DATA_W-1:0] opr_d [14:32];
  logic [DATA_W-1:0] gpr_q [40:NREG-1];
  logic [DATA_W-1:0] gpr_d [40:NREG-1];
  logic [DATA_W-1:0] mul_r_q, mul_r_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mul_state_e        state_q, state_d;

  logic [DATA_W-1:0] src_rd, mv_data, acc_nx;
  logic              run, stall, cond, wr_opr, wr_gpr;

  // Function-unit results are registered copies of the current operands.
  always_comb begin
    res_d[1] = DATA_W'(opr_q[14] == opr_q[15]);
    res_d[2] = DATA_W'(opr_q[16] > opr_q[17]);
    res_d[3] = opr_q[18] + opr_q[19];
    res_d[4] = opr_q[20] - opr_q[21];
    res_d[5] = opr_q[22] | opr_q[23];
    res_d[6] = opr_q[24] & opr_q[25];
    res_d[7] = ~opr_q[26];
    res_d[8] = opr_q[27] << opr_q[28];
    res_d[9] = opr_q[29] >> opr_q[30];
  end

  always_comb begin
    src_rd = '0;
    if (bus.i_src == A_PC)                                 src_rd = pc_q;
    else if (bus.i_src <= A_RES_HI)                        src_rd = res_q[bus.i_src];
    else if (bus.i_src == A_MUL_R)                         src_rd = mul_r_q;
    else if (bus.i_src == A_BUSY)                          src_rd = DATA_W'(state_q == S_RUN);
    else if (bus.i_src >= A_OPR_LO && bus.i_src <= A_MUL_B) src_rd = opr_q[bus.i_src];
    else if (bus.i_src >= A_GPR_LO)                        src_rd = gpr_q[bus.i_src];
  end

  always_comb begin
    run     = (state_q == S_RUN);
    stall   = run && ((bus.i_src == A_MUL_R && !bus.i_lw) ||
                      bus.i_dst == A_MUL_A || bus.i_dst == A_MUL_B);
    mv_data = bus.i_lw ? bus.i_imm : src_rd;
    wr_opr  = !stall && bus.i_dst >= A_OPR_LO && bus.i_dst <= A_MUL_B;
    wr_gpr  = !stall && bus.i_dst >= A_GPR_LO;
    opr_d   = opr_q;
    gpr_d   = gpr_q;
    if (wr_opr) opr_d[bus.i_dst] = mv_data;
    if (wr_gpr) gpr_d[bus.i_dst] = mv_data;

    cond = (bus.i_br_sel ? res_q[1][0] : res_q[2][0]) ^ bus.i_br_inv;
    pc_d = pc_q;
    if (!stall) begin
      if (bus.i_j)              pc_d = bus.i_imm;
      else if (bus.i_br && cond) pc_d = bus.i_imm;
      else                      pc_d = pc_q + DATA_W'(1);
    end
  end

  // Shift-add multiplier: one multiplier bit per RUN cycle, LSB first.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_r_d  = mul_r_q;
    acc_nx   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    case (state_q)
      S_IDLE: begin
        if (wr_opr && bus.i_dst == A_MUL_B) begin
          state_d  = S_RUN;
          mcand_d  = opr_q[31];
          mplier_d = mv_data;
          acc_d    = '0;
          cnt_d    = CNT_W'(DATA_W);
        end
      end
      S_RUN: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          mul_r_d = acc_nx;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q     <= '0;
      mul_r_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      for (int k = 1; k <= 9; k++)     res_q[k] <= '0;
      for (int k = 14; k <= 32; k++)   opr_q[k] <= '0;
      for (int k = 40; k < NREG; k++)  gpr_q[k] <= '0;
    end else begin
      pc_q     <= pc_d;
      mul_r_q  <= mul_r_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      res_q    <= res_d;
      opr_q    <= opr_d;
      gpr_q    <= gpr_d;
    end
  end

  assign bus.o_pc    = pc_q;
  assign bus.o_stall = stall;
endmodule

// File: tb/tb_tta_regfile_p.sv
// tb/tb_tta_regfile_p.sv - directed self-checking bench for tta_regfile_p
module tb_tta_regfile_p;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tta_regfile_p_if #(.DATA_W(16), .ADDR_W(6)) bus ();
  tta_regfile_p #(.DATA_W(16), .ADDR_W(6)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_mv(input logic [5:0] src, input logic [5:0] dst, input logic lw, input logic [15:0] imm);
    bus.i_src = src; bus.i_dst = dst; bus.i_lw = lw; bus.i_imm = imm;
    bus.i_j = 1'b0; bus.i_br = 1'b0; bus.i_br_sel = 1'b0; bus.i_br_inv = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mv(input logic [5:0] src, input logic [5:0] dst);
    set_mv(src, dst, 1'b0, 16'h0); tick();
  endtask

  task automatic li(input logic [15:0] imm, input logic [5:0] dst);
    set_mv(6'd0, dst, 1'b1, imm); tick();
  endtask

  task automatic nop();
    set_mv(6'd0, 6'd0, 1'b0, 16'h0); tick();
  endtask

  task automatic branch(input logic j, input logic sel, input logic inv, input logic [15:0] imm);
    set_mv(6'd0, 6'd0, 1'b0, imm);
    bus.i_j = j; bus.i_br = 1'b1; bus.i_br_sel = sel; bus.i_br_inv = inv;
    tick();
  endtask

  task automatic peek(input logic [5:0] addr, output logic [15:0] v);
    set_mv(addr, 6'd0, 1'b0, 16'h0);
    #1;
    v = dut.src_rd;
  endtask

  logic [15:0] v;
  int          cnt;
  logic        pc_ok;

  initial begin
    set_mv(6'd0, 6'd0, 1'b0, 16'h0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", bus.o_pc, 16'h0);
    chk("rst_stall", bus.o_stall, 1'b0);
    peek(6'd40, v); chk("rst_gpr40", v, 16'h0);
    peek(6'd10, v); chk("rst_mul_r", v, 16'h0);
    peek(6'd12, v); chk("rsvd12_rd", v, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      mv(6'd40, 6'd41);
      chk($sformatf("pc_step%0d", k), bus.o_pc, 16'(k));
    end

    li(16'h1357, 6'd40); mv(6'd40, 6'd41);
    peek(6'd41, v); chk("gpr_copy", v, 16'h1357);

    li(16'd7, 6'd18); li(16'd9, 6'd19);
    peek(6'd3, v); chk("add_early", v, 16'd7);
    nop(); mv(6'd3, 6'd40);
    peek(6'd40, v); chk("add_7_9", v, 16'd16);
    li(16'hFFFF, 6'd18); li(16'd1, 6'd19);
    peek(6'd3, v); chk("add_mid", v, 16'h0008);
    nop(); peek(6'd3, v); chk("add_wrap", v, 16'h0);
    li(16'd3, 6'd20); li(16'd5, 6'd21); nop();
    peek(6'd4, v); chk("sub_wrap", v, 16'hFFFE);
    li(16'h00F0, 6'd26); nop();
    peek(6'd7, v); chk("not", v, 16'hFF0F);
    li(16'd1, 6'd27); li(16'd3, 6'd28); nop();
    peek(6'd8, v); chk("sl_3", v, 16'd8);
    li(16'h8000, 6'd29); li(16'd15, 6'd30); nop();
    peek(6'd9, v); chk("sr_15", v, 16'd1);
    li(16'd16, 6'd30); nop();
    peek(6'd9, v); chk("sr_16", v, 16'd0);

    li(16'd5, 6'd14); li(16'd5, 6'd15); nop();
    branch(1'b0, 1'b1, 1'b0, 16'h20); chk("br_eq_taken", bus.o_pc, 16'h20);
    branch(1'b0, 1'b1, 1'b1, 16'h40); chk("br_eq_inv", bus.o_pc, 16'h21);
    branch(1'b1, 1'b1, 1'b1, 16'h55); chk("j_over_br", bus.o_pc, 16'h55);
    branch(1'b0, 1'b0, 1'b0, 16'h70); chk("br_gt_false", bus.o_pc, 16'h56);
    branch(1'b0, 1'b0, 1'b1, 16'h40); chk("br_gt_inv", bus.o_pc, 16'h40);

    li(16'd300, 6'd31); li(16'd200, 6'd32);
    peek(6'd11, v); chk("busy_first", v, 16'd1);
    chk("busy_nostall", bus.o_stall, 1'b0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      peek(6'd11, v);
      if (v == 16'd1) cnt++;
      else break;
      nop();
    end
    chk("busy_cycles", cnt, 16);
    peek(6'd10, v); chk("mul_300x200", v, 16'd60000);

    set_mv(6'd0, 6'd0, 1'b0, 16'h100); bus.i_j = 1'b1; tick();
    li(16'd200, 6'd32);
    chk("pc_pre_stall", bus.o_pc, 16'h101);
    cnt = 0; pc_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_mv(6'd10, 6'd41, 1'b0, 16'h300); bus.i_j = 1'b1;
      #1;
      if (bus.o_stall) begin
        cnt++;
        if (bus.o_pc !== 16'h101) pc_ok = 1'b0;
        tick();
      end else begin
        tick();
        break;
      end
    end
    chk("stall_cycles", cnt, 16);
    chk("pc_frozen", pc_ok, 1'b1);
    chk("pc_after_stall", bus.o_pc, 16'h300);
    peek(6'd41, v); chk("stalled_read", v, 16'd60000);

    li(16'h1234, 6'd31); li(16'h0100, 6'd32);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      set_mv(6'd0, 6'd31, 1'b1, 16'h7777);
      #1;
      if (bus.o_stall) begin cnt++; tick(); end
      else begin tick(); break; end
    end
    chk("mula_stall", cnt, 16);
    peek(6'd10, v); chk("mul_ovf", v, 16'h3400);
    peek(6'd31, v); chk("mula_late", v, 16'h7777);

    li(16'd3, 6'd32);
    nop(); nop(); nop(); nop();
    peek(6'd11, v); chk("busy_c5", v, 16'd1);
    rst = 1'b1; nop(); rst = 1'b0;
    peek(6'd11, v); chk("abort_busy", v, 16'd0);
    peek(6'd10, v); chk("abort_mul_r", v, 16'd0);
    chk("abort_pc", bus.o_pc, 16'h0);
    chk("abort_stall", bus.o_stall, 1'b0);
    for (int k = 0; k < 20; k++) nop();
    peek(6'd10, v); chk("no_writeback", v, 16'd0);
    li(16'h1234, 6'd0); chk("pc_wr_ignored", bus.o_pc, 16'd21);
    li(16'hAAAA, 6'd3); nop();
    peek(6'd3, v); chk("res_wr_ignored", v, 16'h0);
    li(16'h0055, 6'd11); peek(6'd11, v); chk("busy_wr_ignored", v, 16'h0);
    li(16'h0099, 6'd10); peek(6'd10, v); chk("mulr_wr_ignored", v, 16'h0);
    li(16'h0077, 6'd35); peek(6'd35, v); chk("rsvd35_wr", v, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tta_regfile_p.md
# tta_regfile_p

- Parametrised successor of the move-triggered register file at the heart of the transport-triggered core.
- Each instruction is a single move: source register, or immediate, to destination register.
- Writing an operand register feeds a function unit, whose result register updates on the next clock edge.
- Adds over the previous generation:
  - configurable data and address width;
  - a general-purpose register bank;
  - immediate moves to any writable address;
  - inverted-condition branches;
  - an iterative multiplier that stalls fetch through `o_stall`.

## Interface
- `DATA_W`, 16, datapath, immediate and PC width (≥ 4).
- `ADDR_W`, 6, register address width (≥ 6); GPR count = 2^ADDR_W − 40.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_src`  in  ADDR_W  move source address.
- `i_dst`  in  ADDR_W  move destination address.
- `i_lw`  in  1  move data = `i_imm` instead of `regs[i_src]`.
- `i_imm`  in  DATA_W  immediate / jump target.
- `i_j`  in  1  unconditional jump to `i_imm`.
- `i_br`  in  1  conditional branch to `i_imm`.
- `i_br_sel`  in  1  condition: 1 = EQ_R[0], 0 = GT_R[0].
- `i_br_inv`  in  1  branch when condition is 0.
- `o_pc`  out  DATA_W  current PC (registered).
- `o_stall`  out  1  instruction held; fetch must re-present it (combinational).

## Operation
- Address map, read-only results:
  - 0 PC, 1 EQ_R, 2 GT_R, 3 ADD_R, 4 SUB_R, 5 OR_R, 6 AND_R;
  - 7 NOT_R, 8 SL_R, 9 SR_R, 10 MUL_R, 11 MUL_BUSY;
  - 12–13 reserved.
- Address map, writable operands:
  - 14 EQ_A, 15 EQ_B, 16 GT_A, 17 GT_B, 18 ADD_A, 19 ADD_B;
  - 20 SUB_A, 21 SUB_B, 22 OR_A, 23 OR_B, 24 AND_A, 25 AND_B;
  - 26 NOT_A, 27 SL_A, 28 SL_AMT, 29 SR_A, 30 SR_AMT, 31 MUL_A, 32 MUL_B (trigger).
- Address map, other:
  - 33–39 reserved;
  - 40..2^ADDR_W−1 GPRs.
- Reads of reserved addresses return 0.
- Writes to addresses 0–13 and 33–39 are ignored; the PC still advances.
- Move data = `i_lw ? i_imm : regs[i_src]`. It is written to `i_dst` at the clock edge if `i_dst` is writable and there is no stall.
- Results are recomputed every cycle from the operand registers:
  - EQ_R = (A == B) and GT_R = (A > B unsigned), both zero-extended 0/1;
  - ADD_R and SUB_R are modulo 2^DATA_W;
  - NOT_R = ~NOT_A;
  - SL_R / SR_R are logical shifts by the full unsigned amount; an amount ≥ DATA_W gives 0.
- Multiplier: shift-add, states IDLE → RUN → IDLE.
  - IDLE → RUN on an accepted write to MUL_B. It captures MUL_A (register value) and the move data, and loads counter = DATA_W.
  - RUN: one partial product per cycle, counter decrements each cycle.
  - At counter = 1, MUL_R ← low DATA_W bits of the product; state returns to IDLE.
  - MUL_BUSY reads 1 in RUN, 0 in IDLE.
- Stall: `o_stall` = RUN ∧ (`i_src` == MUL_R ∧ ¬`i_lw`, or `i_dst` ∈ {MUL_A, MUL_B}).
- While stalled: no register write, PC holds, jump and branch are suppressed.
- Reading MUL_BUSY never stalls.
- PC update (when not stalled):
  - `i_j` → `i_imm`;
  - else `i_br` ∧ (cond XOR `i_br_inv`) → `i_imm`;
  - else PC + 1, wrapping from 2^DATA_W−1 to 0.
- `i_j` has priority over `i_br`.

## Timing
- A move presented in cycle c takes effect at the edge ending c.
- A result reflects an operand write from cycle c and is readable by a move in cycle c+2.
- A branch in cycle c uses EQ_R/GT_R as registered at the start of c.
- Multiply triggered in cycle c:
  - MUL_BUSY = 1 for cycles c+1 .. c+DATA_W;
  - MUL_R valid from cycle c+DATA_W+1.
- Reset values:
  - all registers (PC, results, operands, GPRs, MUL_R) = 0;
  - multiplier IDLE; `o_pc` = 0; `o_stall` = 0 in the cycle after reset.
- Reset during RUN aborts the multiply. MUL_R = 0 and no late write-back occurs.

## Test plan
- Reset, then 5 plain moves GPR40→GPR41 → `o_pc` = 0,1,2,3,4,5; reserved src 12 reads 0.
- Immediate moves: 7→ADD_A, 9→ADD_B, then move ADD_R→GPR40 two cycles later → GPR40 = 16. Repeat with 0xFFFF + 1 → ADD_R = 0. SR_A = 0x8000 with SR_AMT = 15 → SR_R = 1; SR_AMT = 16 → SR_R = 0.
- Branch: EQ_A = EQ_B = 5, then `i_br`, `i_br_sel` = 1, `i_imm` = 0x20 → PC = 0x20. Same with `i_br_inv` = 1 → PC + 1. `i_j` and `i_br` together with a false condition → PC = `i_imm`.
- Multiply: MUL_A = 300, MUL_B ← 200 → MUL_BUSY = 1 for exactly 16 cycles, MUL_R = 60000. A MUL_R read issued immediately stalls 16 cycles with PC frozen, then returns 60000.
- Multiply overflow: 0x1234 × 0x0100 → MUL_R = 0x3400. A write to MUL_A during RUN stalls and does not corrupt the product.
- Reset asserted mid-multiply (cycle 5 of RUN) → MUL_BUSY = 0, MUL_R = 0, PC = 0, no write-back afterwards. Writes to PC/result addresses are ignored.
